// File: rtl/mouse_pkg.sv
// Shared types and constants for the PS/2 mouse tracker: FSM states,
// status-byte bit positions and the position width.
package mouse_pkg;

  localparam int POS_W = 12;

  typedef enum logic [1:0] {
    S_B0,
    S_B1,
    S_B2
  } state_t;

  localparam int BTN_L    = 0;
  localparam int BTN_R    = 1;
  localparam int BTN_M    = 2;
  localparam int SYNC_BIT = 3;
  localparam int XSIGN    = 4;
  localparam int YSIGN    = 5;
  localparam int XOVF     = 6;
  localparam int YOVF     = 7;

  // Only the status bits that matter after the sync check are kept.
  typedef struct packed {
    logic y_ovf;
    logic x_ovf;
    logic y_sign;
    logic x_sign;
    logic btn_m;
    logic btn_r;
    logic btn_l;
  } status_t;

endpackage

// File: rtl/mouse_axis_acc.sv
// One axis of the absolute position: sign-extends a 9-bit PS/2 delta,
// squashes it on overflow, adds or subtracts it, and clamps to [0, MAX].
module mouse_axis_acc
  import mouse_pkg::*;
#(
  parameter int MAX    = 767,
  parameter int INIT   = 384,
  parameter bit INVERT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             commit,
  input  logic             sign,
  input  logic             ovf,
  input  logic [7:0]       delta,
  output logic [POS_W-1:0] pos
);

  localparam logic signed [13:0] MAX_S = 14'(MAX);

  logic signed [13:0] delta_ext;
  logic signed [13:0] sum;
  logic [POS_W-1:0]   next_pos;

  // 14-bit signed headroom keeps the sum from wrapping before the clamp.
  always_comb begin
    delta_ext = ovf ? 14'sd0 : $signed({{5{sign}}, sign, delta});
    sum       = INVERT ? ($signed({2'b00, pos}) - delta_ext)
                       : ($signed({2'b00, pos}) + delta_ext);
    if (sum < 14'sd0)
      next_pos = '0;
    else if (sum > MAX_S)
      next_pos = POS_W'(MAX);
    else
      next_pos = sum[POS_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pos <= POS_W'(INIT);
    else if (commit)
      pos <= next_pos;
  end

endmodule

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse packet assembler and absolute cursor tracker.
// Define PS2_MOUSE_TIMEOUT_EN to abort partial packets after an inter-byte gap.
module ps2_mouse_tracker
  import mouse_pkg::*;
#(
`ifdef PS2_MOUSE_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 2_000_000,
`endif
  parameter int X_MAX  = 767,
  parameter int Y_MAX  = 511,
  parameter int X_INIT = 384,
  parameter int Y_INIT = 256
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [POS_W-1:0] mouse_x,
  output logic [POS_W-1:0] mouse_y,
  output logic             btn_left,
  output logic             btn_right,
  output logic             btn_middle,
  output logic             new_event,
  output logic             sync_err
);

  state_t     state;
  state_t     eff_state;
  status_t    status;
  logic [7:0] x_byte;
  logic       timeout_hit;
  logic       commit;

`ifdef PS2_MOUSE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] gap_cnt;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET)
      gap_cnt <= '0;
    else if (rx_valid || state == S_B0 || timeout_hit)
      gap_cnt <= '0;
    else
      gap_cnt <= gap_cnt + 1'b1;
  end

  assign timeout_hit = (state != S_B0) && (gap_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
  assign timeout_hit = 1'b0;
`endif

  // A byte arriving on the timeout cycle is treated as a fresh status byte.
  assign eff_state = timeout_hit ? S_B0 : state;
  assign commit    = rx_valid && (eff_state == S_B2);

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state      <= S_B0;
      status     <= '0;
      x_byte     <= '0;
      btn_left   <= 1'b0;
      btn_right  <= 1'b0;
      btn_middle <= 1'b0;
      new_event  <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      new_event <= commit;
      sync_err  <= timeout_hit;
      if (timeout_hit)
        state <= S_B0;
      if (rx_valid) begin
        case (eff_state)
          S_B0: begin
            if (rx_data[SYNC_BIT]) begin
              status <= '{y_ovf:  rx_data[YOVF],  x_ovf: rx_data[XOVF],
                          y_sign: rx_data[YSIGN], x_sign: rx_data[XSIGN],
                          btn_m:  rx_data[BTN_M], btn_r: rx_data[BTN_R],
                          btn_l:  rx_data[BTN_L]};
              state  <= S_B1;
            end else begin
              state    <= S_B0;
              sync_err <= 1'b1;
            end
          end
          S_B1: begin
            x_byte <= rx_data;
            state  <= S_B2;
          end
          S_B2: begin
            btn_left   <= status.btn_l;
            btn_right  <= status.btn_r;
            btn_middle <= status.btn_m;
            state      <= S_B0;
          end
          default: state <= S_B0;
        endcase
      end
    end
  end

  // The Y byte is consumed straight off rx_data on the commit cycle.
  mouse_axis_acc #(.MAX(X_MAX), .INIT(X_INIT), .INVERT(1'b0)) u_x_axis (
    .clk    (CLOCK),
    .rst    (RESET),
    .commit (commit),
    .sign   (status.x_sign),
    .ovf    (status.x_ovf),
    .delta  (x_byte),
    .pos    (mouse_x)
  );

  mouse_axis_acc #(.MAX(Y_MAX), .INIT(Y_INIT), .INVERT(1'b1)) u_y_axis (
    .clk    (CLOCK),
    .rst    (RESET),
    .commit (commit),
    .sign   (status.y_sign),
    .ovf    (status.y_ovf),
    .delta  (rx_data),
    .pos    (mouse_y)
  );

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Directed self-checking bench for ps2_mouse_tracker; expected positions are
// hand-computed from the PS/2 packet contents.
module tb_ps2_mouse_tracker;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [11:0] mouse_x;
  logic [11:0] mouse_y;
  logic        btn_left;
  logic        btn_right;
  logic        btn_middle;
  logic        new_event;
  logic        sync_err;

  int checks = 0;
  int failures = 0;

  always #5 CLOCK = ~CLOCK;

`ifdef PS2_MOUSE_TIMEOUT_EN
  ps2_mouse_tracker #(.TIMEOUT_CYCLES(100)) dut (
`else
  ps2_mouse_tracker dut (
`endif
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .mouse_x    (mouse_x),
    .mouse_y    (mouse_y),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_middle (btn_middle),
    .new_event  (new_event),
    .sync_err   (sync_err)
  );

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drives one byte for a single cycle; returns at the next negedge.
  task automatic sendByte(input logic [7:0] b);
    @(negedge CLOCK);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge CLOCK);
    rx_valid = 1'b0;
  endtask

  // Back-to-back 3-byte packet; returns at the negedge where the commit is visible.
  task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    @(negedge CLOCK);
    rx_data = b0; rx_valid = 1'b1;
    @(negedge CLOCK);
    rx_data = b1;
    @(negedge CLOCK);
    rx_data = b2;
    @(negedge CLOCK);
    rx_valid = 1'b0;
  endtask

  task automatic doReset();
    @(negedge CLOCK);
    RESET = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(negedge CLOCK);
    RESET = 1'b0;
  endtask

  initial begin
    int ev;
    bit seen;

    repeat (3) @(negedge CLOCK);
    RESET = 1'b0;
    @(negedge CLOCK);
    checkOutput("reset_x", mouse_x, 384);
    checkOutput("reset_y", mouse_y, 256);
    checkOutput("reset_btns", {btn_middle, btn_right, btn_left}, 0);
    checkOutput("reset_new_event", new_event, 0);
    checkOutput("reset_sync_err", sync_err, 0);

    applyStimulus(8'h08, 8'h0A, 8'h05);
    checkOutput("basic_x", mouse_x, 394);
    checkOutput("basic_y", mouse_y, 251);
    checkOutput("basic_btns", {btn_middle, btn_right, btn_left}, 0);
    checkOutput("basic_new_event", new_event, 1);
    @(negedge CLOCK);
    checkOutput("basic_new_event_drop", new_event, 0);
    checkOutput("basic_x_hold", mouse_x, 394);

    doReset();
    applyStimulus(8'h19, 8'h80, 8'h00);
    checkOutput("neg_x_1", mouse_x, 256);
    checkOutput("neg_y_1", mouse_y, 256);
    checkOutput("neg_left", btn_left, 1);
    applyStimulus(8'h19, 8'h80, 8'h00);
    checkOutput("neg_x_2", mouse_x, 128);
    applyStimulus(8'h19, 8'h80, 8'h00);
    checkOutput("neg_x_3", mouse_x, 0);
    applyStimulus(8'h19, 8'h80, 8'h00);
    checkOutput("neg_x_clamp", mouse_x, 0);

    applyStimulus(8'h48, 8'h7F, 8'h10);
    checkOutput("xovf_x", mouse_x, 0);
    checkOutput("xovf_y", mouse_y, 240);
    checkOutput("xovf_new_event", new_event, 1);
    checkOutput("xovf_left_clear", btn_left, 0);

    sendByte(8'h00);
    checkOutput("stray_sync_err", sync_err, 1);
    checkOutput("stray_no_event", new_event, 0);
    @(negedge CLOCK);
    checkOutput("stray_sync_err_drop", sync_err, 0);
    applyStimulus(8'h08, 8'h05, 8'h00);
    checkOutput("after_stray_x", mouse_x, 5);
    checkOutput("after_stray_y", mouse_y, 240);
    checkOutput("after_stray_event", new_event, 1);

    // dy = -255 moves the cursor down: 240 -> 495 -> clamp at 511
    applyStimulus(8'h28, 8'h00, 8'h01);
    checkOutput("ydown_y", mouse_y, 495);
    applyStimulus(8'h28, 8'h00, 8'h01);
    checkOutput("ydown_clamp", mouse_y, 511);

    // 5 + 7*127 = 894 -> clamp at 767
    for (int i = 0; i < 7; i++) applyStimulus(8'h08, 8'h7F, 8'h00);
    checkOutput("xmax_clamp", mouse_x, 767);

    applyStimulus(8'h0E, 8'h00, 8'h00);
    checkOutput("zero_btns", {btn_middle, btn_right, btn_left}, 6);
    checkOutput("zero_event", new_event, 1);
    checkOutput("zero_x", mouse_x, 767);
    checkOutput("zero_y", mouse_y, 511);

    doReset();
    sendByte(8'h08);
    doReset();
    applyStimulus(8'h08, 8'h01, 8'h00);
    ev = 0;
    for (int i = 0; i < 6; i++) begin
      if (new_event) ev++;
      @(negedge CLOCK);
    end
    checkOutput("midreset_commits", ev, 1);
    checkOutput("midreset_x", mouse_x, 385);
    checkOutput("midreset_y", mouse_y, 256);

`ifdef PS2_MOUSE_TIMEOUT_EN
    doReset();
    sendByte(8'h08);
    seen = 1'b0;
    for (int i = 0; i < 150 && !seen; i++) begin
      if (sync_err) seen = 1'b1;
      @(negedge CLOCK);
    end
    checkOutput("timeout_sync_err", seen, 1);
    applyStimulus(8'h08, 8'h02, 8'h00);
    checkOutput("timeout_next_x", mouse_x, 386);
`else
    seen = 1'b0;
    checkOutput("no_timeout_sync_err", sync_err, 0);
`endif

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_tracker.md
Name: ps2_mouse_tracker

Overview:
- Sits directly upstream of the OLED cursor renderer.
- Consumes the byte stream from the PS/2 receiver, assembles standard 3-byte mouse packets, and accumulates signed deltas into absolute, clamped 12-bit mouse_x/mouse_y positions.
- Also provides button states and a one-cycle new_event strobe.
- The cursor renderer divides mouse_x by its sensitivity, so the X range is sized for 96 columns × 8.

Parameters:
- X_MAX, 767, upper clamp for mouse_x (inclusive); lower clamp is 0.
- Y_MAX, 511, upper clamp for mouse_y (inclusive); lower clamp is 0.
- X_INIT, 384, mouse_x value after reset.
- Y_INIT, 256, mouse_y value after reset.
- TIMEOUT_CYCLES, 2_000_000, inter-byte gap that aborts a partial packet (used only with the optional feature).

Ports:
- CLOCK  input  1  system clock, all logic rising-edge.
- RESET  input  1  asynchronous, active-high reset.
- rx_data  input  8  received PS/2 byte.
- rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle.
- mouse_x  output  12  absolute X position, 0..X_MAX.
- mouse_y  output  12  absolute Y position, 0..Y_MAX; increases downward.
- btn_left  output  1  left button, from the last committed packet.
- btn_right  output  1  right button, from the last committed packet.
- btn_middle  output  1  middle button, from the last committed packet.
- new_event  output  1  one-cycle pulse when a packet commits.
- sync_err  output  1  one-cycle pulse when a byte is discarded or a packet is aborted.

Behaviour:
- One clock (CLOCK). RESET is asynchronous and active-high. All outputs are registered.
- Reset values:
  - mouse_x = X_INIT, mouse_y = Y_INIT.
  - Buttons = 0, new_event = 0, sync_err = 0.
  - FSM = S_B0; the internal byte registers are cleared.
  - Reset asserted mid-packet discards the partial packet; no commit occurs.
- FSM states: S_B0 (expect status byte), S_B1 (expect X delta), S_B2 (expect Y delta). State changes only on cycles where rx_valid = 1.
- S_B0 with rx_valid:
  - If rx_data[3] = 1: latch the status byte and go to S_B1.
  - Otherwise: discard the byte, stay in S_B0, pulse sync_err the next cycle.
- S_B1 with rx_valid: latch the X byte, go to S_B2. There is no validity check on this byte.
- S_B2 with rx_valid: commit the packet and return to S_B0. Any rx_valid cadence is accepted, including back-to-back cycles.
- Commit arithmetic:
  - Status bits: [0] left, [1] right, [2] middle, [4] X sign, [5] Y sign, [6] X overflow, [7] Y overflow.
  - dx = {sign_x, xbyte} as signed 9-bit; dy likewise.
  - If an axis's overflow bit is set, that axis's delta is forced to 0. The buttons still update.
  - new_x = mouse_x + dx. new_y = mouse_y − dy (PS/2 positive Y is up; screen Y is down).
  - Evaluate in signed 14-bit, then clamp to [0, X_MAX] / [0, Y_MAX]. Positions never wrap.
- Latency: mouse_x, mouse_y, the buttons, and new_event all update on the clock edge following the cycle in which byte 2 had rx_valid, i.e. visible 1 cycle later. new_event is high for exactly 1 cycle.
- A zero-delta packet still pulses new_event and updates the buttons.
- Outputs hold their values between commits.

Optional Feature:
- Macro: PS2_MOUSE_TIMEOUT_EN.
- With the macro defined:
  - A gap counter clears on every rx_valid and increments each cycle while the state is not S_B0.
  - When the counter reaches TIMEOUT_CYCLES, the FSM returns to S_B0, the partial packet is discarded (no commit), and sync_err pulses for 1 cycle.
  - If rx_valid coincides with the timeout cycle, the byte is processed as if it were in S_B0.
- Without the macro: no counter is present, and a stalled packet waits indefinitely.

Decomposition:
- Shared package mouse_pkg holds:
  - FSM state encoding (S_B0/S_B1/S_B2).
  - Status bit-index constants (BTN_L, BTN_R, BTN_M, SYNC_BIT, XSIGN, YSIGN, XOVF, YOVF).
  - POS_W = 12, the position width.
- Sub-module mouse_axis_acc holds the per-axis logic: sign-extend, overflow squash, add/subtract, clamp.
  - Parameters: MAX and INVERT.
  - It is instantiated twice, once for X and once for Y (INVERT = 1).

Test Plan:
- Reset, then packet 0x08, 0x0A, 0x05 → next cycle mouse_x = 394, mouse_y = 251, buttons 0, new_event pulses once.
- From reset, packet 0x19, 0x80, 0x00 (dx = −128, left) → mouse_x = 256, mouse_y = 256, btn_left = 1; repeat three times → mouse_x clamps at 0 and never wraps.
- Packet 0x48, 0x7F, 0x10 (X overflow) → mouse_x unchanged, mouse_y = 240, new_event pulses.
- Stray byte 0x00 in S_B0 → sync_err pulses, state stays S_B0; the following valid 3-byte packet commits normally.
- RESET asserted after byte 1 of a packet, then a full packet 0x08, 0x01, 0x00 → exactly one commit, mouse_x = 385.
- With PS2_MOUSE_TIMEOUT_EN and TIMEOUT_CYCLES = 100: send 0x08, idle 100 cycles → sync_err pulses; next packet 0x08, 0x02, 0x00 → mouse_x = 386.
